// File: rtl/jk_updown_counter_pkg.sv
// rtl/jk_updown_counter_pkg.sv - shared constants, direction encoding and range-check helpers
`ifndef JK_UPDOWN_COUNTER_DEFS
`define JK_UPDOWN_COUNTER_DEFS
`define DIR_UP   1'b1
`define DIR_DOWN 1'b0
// Bits needed to hold values 0..(x-1)
`define JKC_CLOG2(x) $clog2(x)
// Modulus must be at least 2 and must fit the counter width
`define JKC_RANGE_OK(m, w) (((m) >= 2) && (`JKC_CLOG2(m) <= (w)))
`endif

package jk_updown_counter_pkg;

    typedef enum logic {
        DIR_DOWN_E = `DIR_DOWN,
        DIR_UP_E   = `DIR_UP
    } dir_e;

    // Terminal value for the current direction: top of range going up, zero going down
    function automatic logic is_terminal(input dir_e dir, input logic at_max, input logic at_zero);
        return (dir == DIR_UP_E) ? at_max : at_zero;
    endfunction

endpackage

// File: rtl/jk_updown_counter_cell.sv
// rtl/jk_updown_counter_cell.sv - one bit slice: J/K mux, JK storage, carry/borrow chain
module jk_count_cell (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_up,
    input  logic i_force,
    input  logic i_target,
    input  logic i_chain,
    output logic o_q,
    output logic o_chain
);

    logic r_q;
    logic w_t;
    logic w_j;
    logic w_k;

    // Toggle when every lower bit is 1 (up) or 0 (down); forced edges drive J/K to the target
    assign w_t     = i_enable & i_chain;
    assign w_j     = i_force ? i_target  : w_t;
    assign w_k     = i_force ? ~i_target : w_t;
    assign o_chain = i_chain & (i_up ? r_q : ~r_q);
    assign o_q     = r_q;

    // JK storage: J=K=0 hold, J=K=1 toggle, otherwise set/clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= (w_j & ~r_q) | (~w_k & r_q);
        end
    end

endmodule

// File: rtl/jk_updown_counter.sv
// rtl/jk_updown_counter.sv - cascadable modulo-N up/down counter built from JK bit cells
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_load_err
);

    generate
        if (!`JKC_RANGE_OK(MODULUS, WIDTH)) begin : g_bad_modulus
            $error("jk_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   LP_MOD = (WIDTH + 1)'(MODULUS);

    dir_e             w_dir;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH:0]   w_chain;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_term;
    logic             w_load_bad;
    logic             w_force;
    logic [WIDTH-1:0] w_target;
    logic             w_unused_chain;
    logic             r_wrap;
    logic             r_load_err;

    assign w_dir      = dir_e'(i_up);
    assign w_at_max   = (w_count == LP_MAX);
    assign w_at_zero  = (w_count == '0);
    assign w_term     = is_terminal(w_dir, w_at_max, w_at_zero);
    assign w_load_bad = ({1'b0, i_data} >= LP_MOD);

    // Bits are forced on reset, load and wrap edges; otherwise they follow the toggle chain
    assign w_force  = i_rst | i_load | (i_enable & w_term);
    assign w_target = i_rst        ? '0 :
                      i_load       ? (w_load_bad ? '0 : i_data) :
                      (w_dir == DIR_UP_E) ? '0 : LP_MAX;

    assign w_chain[0]     = 1'b1;
    assign w_unused_chain = w_chain[WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_count_cell u_cell (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_enable (i_enable),
                .i_up     (i_up),
                .i_force  (w_force),
                .i_target (w_target[gi]),
                .i_chain  (w_chain[gi]),
                .o_q      (w_count[gi]),
                .o_chain  (w_chain[gi+1])
            );
        end
    endgenerate

    // Status pulses: wrap on an enabled terminal edge, load error on an out-of-range load
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (i_load) begin
            r_wrap     <= 1'b0;
            r_load_err <= w_load_bad;
        end else if (i_enable) begin
            r_wrap     <= w_term;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign o_count    = w_count;
    assign o_tc       = i_enable & w_term;
    assign o_wrap     = r_wrap;
    assign o_load_err = r_load_err;

endmodule

// File: doc/jk_updown_counter.md
Name: jk_updown_counter

Overview:
- Synchronous modulo-N up/down counter built from a row of JK bit cells.
- Each cell's J/K pair is driven from shared next-state logic.
- It is the consumer stage for the team's JK storage cells: it generates the J/K inputs and consumes the Q outputs.
- Used as a cascadable decade/binary counter in sequencer and timer designs; TC supports ripple-free cascading.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; an illegal value must be rejected by an elaboration-time check.

Ports:
- Clock  input  1  rising-edge clock, the only clock.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  count enable.
- Up  input  1  direction: 1 counts up, 0 counts down.
- Load  input  1  synchronous parallel load.
- Data  input  WIDTH  load value.
- Count  output  WIDTH  current count (registered).
- TC  output  1  terminal count, combinational.
- Wrap  output  1  one-cycle registered pulse after a wrap-around.
- LoadErr  output  1  one-cycle registered pulse after an out-of-range load.

Behaviour:
- Single clock domain, Clock. Reset is synchronous and active-high. Every register updates only on the rising edge of Clock.
- Reset: Count=0, Wrap=0, LoadErr=0 on the first edge with Reset=1. Reset mid-count discards the count; no partial state survives.
- Priority per edge: Reset > Load > Enable. Load wins over Enable even when Enable=1.
- Load, Data < MODULUS: Count<=Data, LoadErr<=0, Wrap<=0.
- Load, Data >= MODULUS: Count<=0, LoadErr<=1 for exactly one cycle, Wrap<=0.
- Enable=1, Up=1:
  - Count==MODULUS-1 -> Count<=0, Wrap<=1.
  - otherwise Count<=Count+1, Wrap<=0.
- Enable=1, Up=0:
  - Count==0 -> Count<=MODULUS-1, Wrap<=1.
  - otherwise Count<=Count-1, Wrap<=0.
- Enable=0, Load=0: Count holds; Wrap and LoadErr return to 0.
- Direction change takes effect on the same edge. There is no pipeline, so latency from any control input to Count is 1 cycle.
- TC = Enable & ((Up & Count==MODULUS-1) | (~Up & Count==0)).
  - TC is purely combinational from registered Count and the live inputs.
  - TC is not gated by Load or Reset; the downstream stage ANDs it with its own priority.
- Per-bit J/K generation:
  - Normal count: bit i has J=K=T_i.
    - Up: T_i = Enable & (all lower bits 1).
    - Down: T_i = Enable & (all lower bits 0).
  - Wrap, load or reset edge: J_i = target_i, K_i = ~target_i, forcing the bit to the target value. Targets are 0, MODULUS-1, Data, or 0 respectively.
  - J=K=0 means hold. J=1,K=1 only ever appears as a toggle request.
- Count never leaves 0..MODULUS-1 after the first reset.
- Behaviour before the first reset is undefined. Verification must not check outputs until after reset.

Decomposition:
- Shared constants include file holds:
  - `define for the direction encoding (DIR_UP=1, DIR_DOWN=0).
  - a log2/range-check helper macro used by the MODULUS elaboration check.
- One natural sub-module: jk_count_cell. One bit slice containing:
  - the J/K mux (toggle vs force-to-target),
  - the JK storage with synchronous active-high reset,
  - Q output and carry/borrow-chain output to the next bit.
- The top level is instantiated WIDTH times via generate, plus the terminal-detect, TC, Wrap and LoadErr logic.

Test Plan:
- Reset=1 for 2 cycles with Enable=1, Up=1, Load=0 -> Count=0, Wrap=0, LoadErr=0 after the first edge; Count still 0 after release until the next enabled edge.
- Defaults (WIDTH=4, MODULUS=10), Enable=1, Up=1 for 12 cycles from 0 -> Count 1..9,0,1,2; TC=1 only while Count=9; Wrap=1 only in the cycle Count=0 follows 9.
- Up=0, Enable=1 from Count=1 for 3 cycles -> Count 0,9,8; TC=1 while Count=0; Wrap pulses once when Count becomes 9.
- Load=1, Data=7 with Enable=1 -> Count=7 next cycle. Then Load=1, Data=12 -> Count=0 and LoadErr=1 for one cycle. Then Load=0, Enable=0 -> Count=0 holds.
- Count=5 counting up; assert Reset and Load (Data=3) on the same edge -> Count=0, LoadErr=0. Next edge with Enable=1 -> Count=1.
- WIDTH=3, MODULUS=8, Enable=1, Up=1 for 9 cycles -> full binary wrap 7->0 with Wrap=1. Also toggle Up every cycle starting at 4 -> Count 5,4,5,4.
